// File: rtl/bus_wrr_arbiter_pkg.sv
// Shared types and default sizing for the weighted round-robin bus arbiter.
package bus_arb_pkg;

  localparam int unsigned DRVS_DEF  = 8;
  localparam int unsigned WGT_W_DEF = 4;
  localparam int unsigned TMO_DEF   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_wrr_arbiter_if.sv
// Request/grant and weight-programming bundle between bus drivers and the arbiter.
interface bus_wrr_arbiter_if #(
  parameter int unsigned DRVS  = 8,
  parameter int unsigned WGT_W = 4
);
  localparam int unsigned IW = $clog2(DRVS);

  logic [DRVS-1:0]  pndng;
  logic             done;
  logic             wgt_we;
  logic [IW-1:0]    wgt_idx;
  logic [WGT_W-1:0] wgt_data;
  logic [DRVS-1:0]  gnt;
  logic             gnt_vld;
  logic [IW-1:0]    gnt_id;
  logic             err_tmo;

  modport master (
    output pndng, done, wgt_we, wgt_idx, wgt_data,
    input  gnt, gnt_vld, gnt_id, err_tmo
  );

  modport slave (
    input  pndng, done, wgt_we, wgt_idx, wgt_data,
    output gnt, gnt_vld, gnt_id, err_tmo
  );
endinterface

// File: rtl/bus_wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request after ptr, wrapping modulo DRVS.
module rr_pick #(
  parameter int unsigned DRVS = 8,
  localparam int unsigned IW  = $clog2(DRVS)
) (
  input  logic [DRVS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [DRVS-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    logic [IW-1:0] p;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = '0;
    for (int unsigned k = DRVS; k >= 1; k--) begin
      p = IW'((32'(ptr) + k) % DRVS);
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = p;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_wrr_arbiter.sv
// Weighted round-robin bus arbiter with per-holder packet credit and grant timeout.
module bus_wrr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned DRVS  = DRVS_DEF,
  parameter int unsigned WGT_W = WGT_W_DEF,
  parameter int unsigned TMO   = TMO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  bus_wrr_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(DRVS);
  localparam int unsigned TW = $clog2(TMO + 1);

  arb_state_e       state_q, state_d;
  logic [DRVS-1:0]  gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [IW-1:0]    id_q, id_d;
  logic             err_q, err_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WGT_W-1:0] wgt_q [DRVS];

  logic [DRVS-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.DRVS(DRVS)) u_pick (
    .req (bus.pndng),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Weight table; a load in the same cycle as a write sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DRVS; i++) wgt_q[i] <= WGT_W'(1);
    end else if (bus.wgt_we) begin
      wgt_q[bus.wgt_idx] <= bus.wgt_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      err_q    <= 1'b0;
      credit_q <= '0;
      tmo_q    <= '0;
      ptr_q    <= IW'(DRVS - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
      err_q    <= err_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      ptr_q    <= ptr_d;
    end
  end

  // Next-state: grant on any request from IDLE; release on credit exhaustion, drop or timeout.
  always_comb begin
    logic release_c;
    state_d   = state_q;
    gnt_d     = gnt_q;
    vld_d     = vld_q;
    id_d      = id_q;
    err_d     = 1'b0;
    credit_d  = credit_q;
    tmo_d     = tmo_q;
    ptr_d     = ptr_q;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = GRANT;
          gnt_d    = pick_gnt;
          vld_d    = 1'b1;
          id_d     = pick_idx;
          credit_d = (wgt_q[pick_idx] == '0) ? WGT_W'(1) : wgt_q[pick_idx];
          tmo_d    = '0;
        end
      end
      GRANT: begin
        if (bus.done) begin
          tmo_d = '0;
          if (credit_q > WGT_W'(1) && bus.pndng[id_q]) credit_d = credit_q - WGT_W'(1);
          else release_c = 1'b1;
        end else if (!bus.pndng[id_q]) begin
          release_c = 1'b1;
        end else if (tmo_q == TW'(TMO - 1)) begin
          release_c = 1'b1;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        if (release_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld_q;
  assign bus.gnt_id  = id_q;
  assign bus.err_tmo = err_q;

endmodule

// File: tb/tb_bus_wrr_arbiter.sv
// Directed bench for bus_wrr_arbiter with hand-computed grant sequences.
module tb_bus_wrr_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  bus_wrr_arbiter_if #(.DRVS(8), .WGT_W(4)) bus ();

  bus_wrr_arbiter #(.DRVS(8), .WGT_W(4), .TMO(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input string tag, input int id);
    logic [7:0] oh;
    oh = 8'd1 << id;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
    chk({tag, ".vld"}, 32'(bus.gnt_vld), 32'd1);
    chk({tag, ".id"},  32'(bus.gnt_id), 32'(id));
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".gnt0"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".vld0"}, 32'(bus.gnt_vld), 32'd0);
  endtask

  task automatic wr_wgt(input int idx, input int val);
    bus.wgt_we   = 1'b1;
    bus.wgt_idx  = 3'(idx);
    bus.wgt_data = 4'(val);
    tick();
    bus.wgt_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int seq_a [4];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.pndng    = '0;
    bus.done     = 1'b0;
    bus.wgt_we   = 1'b0;
    bus.wgt_idx  = '0;
    bus.wgt_data = '0;
    #12;
    exp_idle("rst");
    chk("rst.id",  32'(bus.gnt_id), 32'd0);
    chk("rst.err", 32'(bus.err_tmo), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    exp_idle("rst_rel");

    // Drivers 0 and 2 alternate, one bubble between grants.
    seq_a = '{0, 2, 0, 2};
    bus.pndng = 8'b0000_0101;
    foreach (seq_a[i]) begin
      tick();
      exp_gnt($sformatf("alt%0d", i), seq_a[i]);
      tick();
      exp_gnt($sformatf("alt%0d_hold", i), seq_a[i]);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      exp_idle($sformatf("alt%0d_rel", i));
      chk($sformatf("alt%0d_idhold", i), 32'(bus.gnt_id), 32'(seq_a[i]));
    end
    bus.pndng = '0;
    tick();
    exp_idle("alt_end");

    // Weight 3 on driver 3: one grant spans three done pulses.
    wr_wgt(3, 3);
    bus.pndng = 8'b0000_1000;
    tick();
    exp_gnt("w3.load", 3);
    for (int d = 0; d < 3; d++) begin
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      if (d < 2) begin
        exp_gnt($sformatf("w3.done%0d", d), 3);
        tick();
        exp_gnt($sformatf("w3.gap%0d", d), 3);
      end else begin
        exp_idle("w3.rel");
      end
    end
    bus.pndng = '0;
    tick();

    // Timeout on driver 1 after 16 cycles without done.
    bus.pndng = 8'b0000_0010;
    tick();
    exp_gnt("tmo.load", 1);
    for (int c = 1; c < 16; c++) begin
      tick();
      chk($sformatf("tmo.hold%0d", c), 32'(bus.gnt), 32'h2);
      chk($sformatf("tmo.noerr%0d", c), 32'(bus.err_tmo), 32'd0);
    end
    tick();
    exp_idle("tmo.rel");
    chk("tmo.err", 32'(bus.err_tmo), 32'd1);
    // ptr now 1: drivers 1 and 2 pending must pick 2.
    bus.pndng = 8'b0000_0110;
    tick();
    chk("tmo.err_clr", 32'(bus.err_tmo), 32'd0);
    exp_gnt("tmo.ptr", 2);
    bus.pndng = '0;
    tick();
    exp_idle("drop2");
    chk("drop2.err", 32'(bus.err_tmo), 32'd0);

    // Driver 5 withdraws its request mid-grant.
    bus.pndng = 8'b0010_0000;
    tick();
    exp_gnt("drop5.load", 5);
    tick();
    exp_gnt("drop5.hold", 5);
    bus.pndng = '0;
    tick();
    exp_idle("drop5.rel");
    chk("drop5.err", 32'(bus.err_tmo), 32'd0);

    // Full fairness rotation from a fresh reset.
    do_reset();
    bus.pndng = 8'hFF;
    bus.done  = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      exp_gnt($sformatf("rot%0d", e), e % 8);
      tick();
      exp_idle($sformatf("rot%0d_bub", e));
    end
    bus.done  = 1'b0;
    bus.pndng = '0;
    tick();

    // Asynchronous reset mid-grant restores weight 4 to 1.
    wr_wgt(4, 7);
    bus.pndng = 8'b0001_0000;
    tick();
    exp_gnt("ar.load", 4);
    reset = 1'b1;
    #1;
    exp_idle("ar.async");
    chk("ar.id",  32'(bus.gnt_id), 32'd0);
    chk("ar.err", 32'(bus.err_tmo), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    exp_gnt("ar.regrant", 4);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    exp_idle("ar.wgt1");
    bus.pndng = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
